// File: rtl/hex_display_driver.sv
// hex_display_driver: sequential double-dabble of a 17-bit GPIO write onto five active-low 7-seg displays.
// Latency 18 cycles from write to display update; one-deep pending buffer (latest wins) absorbs writes while busy.
// Optional macro HEX_BLANK_LEADING_ZEROS_EN blanks leading zero digits (HEX0 always shown).
module hex_display_driver #(
  parameter int NBITS   = 17,
  parameter int NDIGITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gpio_we,
  input  logic [31:0]          gpio_data,
  output logic                 busy,
  output logic [4*NDIGITS-1:0] bcd,
  output logic [6:0]           HEX0,
  output logic [6:0]           HEX1,
  output logic [6:0]           HEX2,
  output logic [6:0]           HEX3,
  output logic [6:0]           HEX4
);

  localparam int BW = 4 * NDIGITS;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] bin_q, pend_dat, cap_val;
  logic             pend_vld, ovf_q;
  logic             capture, do_shift, do_update;
  logic [4:0]       cnt_q;
  logic [BW-1:0]    acc_q, acc_adj, bcd_q;
  logic [6:0]       hex_q [NDIGITS];
  logic [NDIGITS-1:0] blank;
  logic             unused_hi_bits;

  assign unused_hi_bits = ^gpio_data[31:NBITS];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    do_shift  = 1'b0;
    do_update = 1'b0;
    case (state_q)
      IDLE: begin
        if (gpio_we || pend_vld) begin
          capture = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        do_shift = 1'b1;
        if (cnt_q == 5'(NBITS - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        do_update = 1'b1;
        if (gpio_we || pend_vld) begin
          capture = 1'b1;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh write beats a buffered one; the buffered value is then dropped.
  assign cap_val = gpio_we ? gpio_data[NBITS-1:0] : pend_dat;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < NDIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    blank = '0;
`ifdef HEX_BLANK_LEADING_ZEROS_EN
    begin : lead_zero
      logic lead;
      lead = 1'b1;
      for (int i = NDIGITS - 1; i >= 1; i--) begin
        if (acc_q[4*i +: 4] != 4'd0) lead = 1'b0;
        blank[i] = lead;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_dat <= '0;
    end else if (capture) begin
      pend_vld <= 1'b0;
    end else if (gpio_we && state_q != IDLE) begin
      pend_vld <= 1'b1;
      pend_dat <= gpio_data[NBITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (capture) begin
      bin_q <= cap_val;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= (cap_val > NBITS'(99999));
    end else if (do_shift) begin
      {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
      cnt_q          <= cnt_q + 5'd1;
    end
  end

  // Displays only move here, so intermediate accumulator values never show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      for (int i = 0; i < NDIGITS; i++) hex_q[i] <= SEG_BLANK;
    end else if (do_update) begin
      bcd_q <= ovf_q ? {NDIGITS{4'h9}} : acc_q;
      for (int i = 0; i < NDIGITS; i++) begin
        if (ovf_q)         hex_q[i] <= SEG_DASH;
        else if (blank[i]) hex_q[i] <= SEG_BLANK;
        else               hex_q[i] <= seg7(acc_q[4*i +: 4]);
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign bcd  = bcd_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];

endmodule

// File: tb/tb_hex_display_driver.sv
// Randomized bench for hex_display_driver with a cycle-count reference model and literal spot checks.
module tb_hex_display_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gpio_we = 1'b0;
  logic [31:0] gpio_data = '0;
  logic        busy;
  logic [19:0] bcd;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4;

  int errors = 0;
  int checks = 0;

  hex_display_driver dut (
    .clk(clk), .rst_n(rst_n), .gpio_we(gpio_we), .gpio_data(gpio_data),
    .busy(busy), .bcd(bcd),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DA = 7'b0111111;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] dut_hex();
    return {HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  // Reference model: a conversion is a countdown of 18 edges ending in a display update.
  bit         m_active = 0;
  int         m_remaining = 0;
  int         m_cur = 0;
  bit         m_pv = 0;
  int         m_pend = 0;
  logic [19:0] m_bcd = '0;
  logic [6:0]  m_hex [5] = '{BL, BL, BL, BL, BL};

  task automatic show(input int v);
    int p;
    int d;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      if (v > 99999) begin
        m_bcd[4*i +: 4] = 4'h9;
        m_hex[i] = DA;
      end else begin
        d = (v / p) % 10;
        m_bcd[4*i +: 4] = d[3:0];
        m_hex[i] = seg_tab[d];
`ifdef HEX_BLANK_LEADING_ZEROS_EN
        if (i > 0 && v < p) m_hex[i] = BL;
`endif
      end
      p = p * 10;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_remaining = 0; m_pv = 0; m_bcd = '0;
      for (int i = 0; i < 5; i++) m_hex[i] = BL;
    end else if (!m_active) begin
      if (gpio_we) begin
        m_active = 1; m_remaining = 18; m_cur = int'(gpio_data[16:0]);
      end
    end else begin
      m_remaining--;
      if (m_remaining == 0) begin
        show(m_cur);
        if (gpio_we) begin
          m_cur = int'(gpio_data[16:0]); m_remaining = 18; m_pv = 0;
        end else if (m_pv) begin
          m_cur = m_pend; m_remaining = 18; m_pv = 0;
        end else begin
          m_active = 0;
        end
      end else if (gpio_we) begin
        m_pend = int'(gpio_data[16:0]); m_pv = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_active));
    chk("bcd", 64'(bcd), 64'(m_bcd));
    chk("hex", 64'(dut_hex()), 64'({m_hex[4], m_hex[3], m_hex[2], m_hex[1], m_hex[0]}));
  end

  task automatic write(input logic [31:0] d);
    @(posedge clk); #1;
    gpio_we = 1'b1; gpio_data = d;
    @(posedge clk); #1;
    gpio_we = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("wait_idle_timeout", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 999));
      1: return 32'($urandom_range(0, 99999));
      2: return 32'($urandom_range(99990, 100010));
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [34:0] zero_hex, h305;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("reset_hex", 64'(dut_hex()), 64'({BL, BL, BL, BL, BL}));
    chk("reset_bcd", 64'(bcd), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    write(32'd12345);
    n = 1;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      if (busy) n++;
    end
    chk("busy_cycles", 64'(n), 64'd18);
    chk("bcd_12345", 64'(bcd), 64'h12345);
    chk("hex_12345", 64'(dut_hex()),
        64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}));

    write(32'hFFFF_FFFF);
    wait_idle(40);
    chk("ovf_bcd", 64'(bcd), 64'h99999);
    chk("ovf_hex", 64'(dut_hex()), 64'({DA, DA, DA, DA, DA}));

    write(32'd42);
    repeat (2) @(posedge clk); #1;
    gpio_we = 1'b1; gpio_data = 32'd7;
    @(posedge clk); #1;
    gpio_data = 32'd99999;
    @(posedge clk); #1;
    gpio_we = 1'b0;
    n = 0;
    while (bcd !== 20'h00042 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_bcd_42", 64'(bcd), 64'h00042);
    chk("b2b_no_idle", 64'(busy), 64'd1);
    wait_idle(40);
    chk("b2b_bcd_99999", 64'(bcd), 64'h99999);
    chk("b2b_hex_99999", 64'(dut_hex()), 64'({5{7'b0010000}}));

    write(32'd305);
    wait_idle(40);
`ifdef HEX_BLANK_LEADING_ZEROS_EN
    h305 = {BL, BL, 7'b0110000, 7'b1000000, 7'b0010010};
    zero_hex = {BL, BL, BL, BL, 7'b1000000};
`else
    h305 = {7'b1000000, 7'b1000000, 7'b0110000, 7'b1000000, 7'b0010010};
    zero_hex = {5{7'b1000000}};
`endif
    chk("hex_305", 64'(dut_hex()), 64'(h305));
    chk("bcd_305", 64'(bcd), 64'h00305);

    write(32'd0);
    wait_idle(40);
    chk("hex_0", 64'(dut_hex()), 64'(zero_hex));

    write(32'd54321);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_hex", 64'(dut_hex()), 64'({BL, BL, BL, BL, BL}));
    chk("rst_mid_bcd", 64'(bcd), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (25) @(posedge clk); #1;
    chk("rst_no_update", 64'(dut_hex()), 64'({BL, BL, BL, BL, BL}));

    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      gpio_we = ($urandom_range(0, 7) == 0);
      gpio_data = rnd_data();
    end
    @(posedge clk); #1;
    gpio_we = 1'b0;
    wait_idle(100);
    repeat (3) @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
